// File: rtl/fp_add_normalizer.sv
// Back end of the sequential single-precision adder: left-renormalises the raw
// aligned sum one bit per cycle, rounds to nearest-even and packs the result.
module fp_add_normalizer #(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int MAX_SHIFT = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [FRAC_W+4:0]     in_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  ovf,
  output logic                  unf,
  output logic                  zero
);
  localparam int MW = FRAC_W + 5;
  localparam int EW = EXP_W + 2;
  localparam int RW = EXP_W + FRAC_W + 1;
  localparam int CW = $clog2(MAX_SHIFT + 1);
  localparam logic signed [EW-1:0] E_ZERO  = EW'(0);
  localparam logic signed [EW-1:0] E_ONE   = EW'(1);
  localparam logic signed [EW-1:0] E_MAX   = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]        CNT_MAX = CW'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s, w_s_nxt;
  logic signed [EW-1:0]  r_e, w_e_nxt, w_e_rnd;
  logic [MW-1:0]         r_m, w_m_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [RW-1:0]         r_result, w_result_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic                  r_unf, w_unf_nxt;
  logic                  r_zero, w_zero_nxt;
  logic [FRAC_W+1:0]     w_mr;
  logic [FRAC_W-1:0]     w_frac;

  // Takes {hidden, frac, G, R, S}; returns {carry, hidden, frac} after RNE.
  function automatic logic [FRAC_W+1:0] rne_round(input logic [MW-2:0] mv);
    logic inc;
    inc = mv[2] & (mv[1] | mv[0] | mv[3]);
    return {1'b0, mv[MW-2:3]} + (FRAC_W+2)'(inc);
  endfunction

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign zero      = r_zero;

  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_e_nxt      = r_e;
    w_m_nxt      = r_m;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_zero_nxt   = r_zero;
    w_mr         = rne_round(r_m[MW-2:0]);
    w_e_rnd      = r_e + (w_mr[FRAC_W+1] ? E_ONE : E_ZERO);
    // A rounding carry renormalises right by one; the fraction is then all zero.
    w_frac       = w_mr[FRAC_W+1] ? w_mr[FRAC_W:1] : w_mr[FRAC_W-1:0];
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_s_nxt     = in_sign;
          w_e_nxt     = $signed({2'b00, in_exp});
          w_m_nxt     = in_mant;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_zero_nxt  = 1'b0;
          w_state_nxt = NORM;
        end
      end
      NORM: begin
        if (r_e == E_MAX) begin
          w_result_nxt = {r_s, {EXP_W{1'b1}}, r_m[MW-3:3]};
          w_ovf_nxt    = 1'b0;
          w_unf_nxt    = 1'b0;
          w_zero_nxt   = 1'b0;
          w_state_nxt  = DONE;
        end else if (r_m == '0) begin
          w_result_nxt = '0;
          w_zero_nxt   = 1'b1;
          w_state_nxt  = DONE;
        end else if (r_m[MW-1]) begin
          w_m_nxt     = {1'b0, r_m[MW-1:2], r_m[1] | r_m[0]};
          w_e_nxt     = r_e + E_ONE;
          w_state_nxt = ROUND;
        end else if (r_m[MW-2]) begin
          w_state_nxt = ROUND;
        end else if ((r_e <= E_ONE) || (r_cnt == CNT_MAX)) begin
          // No denormals: anything that cannot reach a normal exponent flushes.
          w_result_nxt = {r_s, {(RW-1){1'b0}}};
          w_unf_nxt    = 1'b1;
          w_state_nxt  = DONE;
        end else begin
          w_m_nxt   = {r_m[MW-2:0], 1'b0};
          w_e_nxt   = r_e - E_ONE;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ROUND: begin
        if (w_e_rnd >= E_MAX) begin
          w_result_nxt = {r_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          w_ovf_nxt    = 1'b1;
        end else begin
          w_result_nxt = {r_s, w_e_rnd[EXP_W-1:0], w_frac};
        end
        w_e_nxt     = w_e_rnd;
        w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

  // Working registers are only read after IDLE has reloaded them.
  always_ff @(posedge clk) begin
    r_s   <= w_s_nxt;
    r_e   <= w_e_nxt;
    r_m   <= w_m_nxt;
    r_cnt <= w_cnt_nxt;
  end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Scoreboard bench for fp_add_normalizer: directed operands with expected
// packed results, flags and latency (edges from acceptance to first valid).
module tb_fp_add_normalizer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_sign, out_ready;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_ready, out_valid, ovf, unf, zero;
  logic [31:0] result;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf, unf, zero;
    int          lat;
  } exp_t;
  exp_t sb[$];

  fp_add_normalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .unf(unf), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, req);
    end
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit hold);
    exp_t x;
    int   n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
    x = sb.pop_front();
    chk({x.tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({x.tag, "_lat"},   n, x.lat);
    chk({x.tag, "_res"},   result, x.res);
    chk({x.tag, "_flags"}, {29'd0, ovf, unf, zero}, {29'd0, x.ovf, x.unf, x.zero});
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h10; in_mant = 28'h8000000;
        chk({x.tag, "_hold_res"},  result, x.res);
        chk({x.tag, "_hold_vld"},  {31'd0, out_valid}, 32'd1);
        chk({x.tag, "_hold_irdy"}, {31'd0, in_ready}, 32'd0);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({x.tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    chk({x.tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic op(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                    input logic [31:0] res, input logic o, input logic u, input logic z,
                    input int lat, input bit hold);
    exp_t x;
    x.tag = tag; x.res = res; x.ovf = o; x.unf = u; x.zero = z; x.lat = lat;
    sb.push_back(x);
    send(s, e, m);
    collect(hold);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result, 32'd0);
    chk("rst_flags",     {29'd0, ovf, unf, zero}, 32'd0);

    //  tag          s     exp    mant           result        o  u  z  lat hold
    op("one_plus_one", 0, 8'h7F, 28'h8000000, 32'h40000000, 0, 0, 0, 3, 0);
    op("sub_shift2",   0, 8'h7F, 28'h1000000, 32'h3E800000, 0, 0, 0, 5, 0);
    op("cancel",       1, 8'h7F, 28'h0000000, 32'h00000000, 0, 0, 1, 2, 0);
    op("rne_up",       0, 8'h7F, 28'h400000C, 32'h3F800002, 0, 0, 0, 3, 0);
    op("rne_tie_even", 0, 8'h7F, 28'h4000004, 32'h3F800000, 0, 0, 0, 3, 0);
    op("rne_gr_up",    0, 8'h7F, 28'h4000006, 32'h3F800001, 0, 0, 0, 3, 0);
    op("rnd_carry",    0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 0, 0, 0, 3, 0);
    op("neg_two",      1, 8'h80, 28'h4000000, 32'hC0000000, 0, 0, 0, 3, 0);
    op("overflow",     0, 8'hFE, 28'h8000000, 32'h7F800000, 1, 0, 0, 3, 0);
    op("underflow",    0, 8'h01, 28'h2000000, 32'h00000000, 0, 1, 0, 2, 0);
    op("flush_shift",  1, 8'h03, 28'h0800000, 32'h80000000, 0, 1, 0, 4, 0);
    op("bypass_nan",   1, 8'hFF, 28'h4000008, 32'hFF800001, 0, 0, 0, 2, 0);
    op("max_shift",    0, 8'h7F, 28'h0000002, 32'h33000000, 0, 0, 0, 28, 0);
    op("shift_guard",  0, 8'h7F, 28'h0000001, 32'h00000000, 0, 1, 0, 27, 0);
    op("hold_done",    0, 8'h7F, 28'h8000000, 32'h40000000, 0, 0, 0, 3, 1);

    // Reset in the middle of a long renormalisation discards the operation.
    send(1'b0, 8'h7F, 28'h0000002);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result",    result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_output", seen, 0);

    op("after_reset", 0, 8'h7F, 28'h8000000, 32'h40000000, 0, 0, 0, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
